cpu_evolution_pio_in_irq: RTL and testbench

//  Parametrised successor of the input-only PIO: an Avalon-MM slave that samples WIDTH

---
 rtl/cpu_evolution_pio_pkg.sv | 15 +
 rtl/cpu_evolution_pio_debounce.sv | 55 +++++
 rtl/cpu_evolution_pio_in_irq.sv | 102 ++++++++++
 tb/tb_cpu_evolution_pio_in_irq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_evolution_pio_pkg.sv
// Shared register map and edge-type encodings for the PIO input block.
package cpu_evolution_pio_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_DATA     = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_EDGE_CAP = 2'd2;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/cpu_evolution_pio_debounce.sv
// One input bit: synchroniser chain followed by a hold-time debounce filter.
module cpu_evolution_pio_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter logic        RESET_VALUE     = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic stable
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign stable = sync;
    end else begin : g_filter
      localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] cnt_q;
      logic             stable_q;

      // A new level is accepted only after it has differed from stable for N cycles.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_q    <= '0;
          stable_q <= RESET_VALUE;
        end else if (sync == stable_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
          stable_q <= sync;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end

      assign stable = stable_q;
    end
  endgenerate

endmodule

// File: rtl/cpu_evolution_pio_in_irq.sv
// Avalon-MM input PIO with debounced pins, sticky edge capture and a maskable
// level interrupt; read data has one cycle of latency.
module cpu_evolution_pio_in_irq
  import cpu_evolution_pio_pkg::*;
#(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      SYNC_STAGES     = 2,
  parameter int unsigned      DEBOUNCE_CYCLES = 4,
  parameter int unsigned      EDGE_TYPE       = EDGE_ANY,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);

  logic [WIDTH-1:0]  stable;
  logic [WIDTH-1:0]  stable_d;
  logic [WIDTH-1:0]  irq_mask;
  logic [WIDTH-1:0]  edge_capture;
  logic [WIDTH-1:0]  edge_event_c;
  logic [WIDTH-1:0]  mask_nxt_c;
  logic [WIDTH-1:0]  cap_nxt_c;
  logic [DATA_W-1:0] rdata_c;
  logic              wr_en_c;
  logic              unused_wdata_c;

  generate
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
      cpu_evolution_pio_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_VALUE    (RESET_VALUE[i])
      ) u_debounce (
        .clk    (clk),
        .reset_n(reset_n),
        .pin    (in_port[i]),
        .stable (stable[i])
      );
    end
  endgenerate

  // Upper write-data bits have no storage behind them.
  assign unused_wdata_c = ^writedata;

  // Edge selection on the debounced level.
  always_comb begin
    edge_event_c = stable ^ stable_d;
    if (EDGE_TYPE == EDGE_RISE) begin
      edge_event_c = stable & ~stable_d;
    end else if (EDGE_TYPE == EDGE_FALL) begin
      edge_event_c = ~stable & stable_d;
    end
  end

  // Register updates; a fresh edge is ORed in after W1C so it is never lost.
  always_comb begin
    wr_en_c    = chipselect & ~write_n;
    mask_nxt_c = irq_mask;
    cap_nxt_c  = edge_capture | edge_event_c;
    if (wr_en_c && (address == ADDR_IRQ_MASK)) begin
      mask_nxt_c = writedata[WIDTH-1:0];
    end
    if (wr_en_c && (address == ADDR_EDGE_CAP)) begin
      cap_nxt_c = (edge_capture & ~writedata[WIDTH-1:0]) | edge_event_c;
    end
  end

  always_comb begin
    rdata_c = '0;
    case (address)
      ADDR_DATA:     rdata_c[WIDTH-1:0] = stable;
      ADDR_IRQ_MASK: rdata_c[WIDTH-1:0] = irq_mask;
      ADDR_EDGE_CAP: rdata_c[WIDTH-1:0] = edge_capture;
      default:       rdata_c = '0;
    endcase
  end

  // irq is computed from next-state values so it always matches capture & mask.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_d     <= RESET_VALUE;
      irq_mask     <= '0;
      edge_capture <= '0;
      readdata     <= '0;
      irq          <= 1'b0;
    end else begin
      stable_d     <= stable;
      irq_mask     <= mask_nxt_c;
      edge_capture <= cap_nxt_c;
      readdata     <= rdata_c;
      irq          <= |(cap_nxt_c & mask_nxt_c);
    end
  end

endmodule

// File: tb/tb_cpu_evolution_pio_in_irq.sv
// Self-checking bench: register table, directed timing sequences and random traffic vs a model.
module tb_cpu_evolution_pio_in_irq;

  localparam int S = 2;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic [3:0]  in_port = 4'h0;
  logic        irq;

  int n_chk = 0;
  int n_fail = 0;
  bit mchk = 1'b0;

  cpu_evolution_pio_in_irq #(
    .WIDTH(4), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(N), .EDGE_TYPE(2), .RESET_VALUE(4'h0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A pin level is taken once its synchronised copy has disagreed with the
  // accepted level for N consecutive cycles; edges are flagged one cycle later.
  logic [3:0]  pin_hist[$];
  logic [3:0]  m_stable, m_stable_old, m_cap, m_mask;
  logic [31:0] m_rd;
  logic        m_irq;
  int          m_hold[4];
  logic [3:0]  sync_prev, ev, stable_new, clr;
  bit          wr;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pin_hist.delete();
      m_stable = 4'h0; m_stable_old = 4'h0; m_cap = 4'h0; m_mask = 4'h0;
      m_rd = 32'h0; m_irq = 1'b0;
      for (int i = 0; i < 4; i++) m_hold[i] = 0;
    end else begin
      sync_prev = (pin_hist.size() >= S) ? pin_hist[S-1] : 4'h0;
      ev = m_stable ^ m_stable_old;
      stable_new = m_stable;
      for (int i = 0; i < 4; i++) begin
        m_hold[i] = (sync_prev[i] != m_stable[i]) ? m_hold[i] + 1 : 0;
        if (m_hold[i] >= N) begin
          stable_new[i] = sync_prev[i];
          m_hold[i] = 0;
        end
      end
      wr = chipselect && !write_n;
      clr = (wr && address == 2'd2) ? writedata[3:0] : 4'h0;
      case (address)
        2'd0: m_rd = {28'h0, m_stable};
        2'd1: m_rd = {28'h0, m_mask};
        2'd2: m_rd = {28'h0, m_cap};
        default: m_rd = 32'h0;
      endcase
      m_cap = (m_cap & ~clr) | ev;
      if (wr && address == 2'd1) m_mask = writedata[3:0];
      m_irq = |(m_cap & m_mask);
      m_stable_old = m_stable;
      m_stable = stable_new;
      pin_hist.push_front(in_port);
      if (pin_hist.size() > S + 2) void'(pin_hist.pop_back());
    end
  end

  always @(negedge clk) begin
    if (mchk) begin
      chk("model_readdata", readdata, m_rd);
      chk("model_irq", {31'h0, irq}, {31'h0, m_irq});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus(input logic [1:0] a, input logic w, input logic [31:0] wd);
    address = a; chipselect = w; write_n = ~w; writedata = wd;
    cycle();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[13];
  int   left[4];

  initial begin
    // readdata after each entry is the register value before that entry's write
    tbl[0]  = '{2'd0, 1'b0, 32'h0,         32'h0, 1'b0};
    tbl[1]  = '{2'd1, 1'b0, 32'h0,         32'h0, 1'b0};
    tbl[2]  = '{2'd2, 1'b0, 32'h0,         32'h0, 1'b0};
    tbl[3]  = '{2'd1, 1'b1, 32'hFFFF_FFFA, 32'h0, 1'b0};
    tbl[4]  = '{2'd1, 1'b0, 32'h0,         32'hA, 1'b0};
    tbl[5]  = '{2'd1, 1'b1, 32'h0,         32'hA, 1'b0};
    tbl[6]  = '{2'd1, 1'b0, 32'h0,         32'h0, 1'b0};
    tbl[7]  = '{2'd3, 1'b1, 32'hF,         32'h0, 1'b0};
    tbl[8]  = '{2'd3, 1'b0, 32'h0,         32'h0, 1'b0};
    tbl[9]  = '{2'd0, 1'b1, 32'hF,         32'h0, 1'b0};
    tbl[10] = '{2'd0, 1'b0, 32'h0,         32'h0, 1'b0};
    tbl[11] = '{2'd2, 1'b1, 32'hF,         32'h0, 1'b0};
    tbl[12] = '{2'd2, 1'b0, 32'h0,         32'h0, 1'b0};

    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    mchk = 1'b1;
    chk("reset_readdata", readdata, 32'h0);
    chk("reset_irq", {31'h0, irq}, 32'h0);

    // Register map, masking of upper bits and ignored writes
    for (int i = 0; i < 13; i++) begin
      bus(tbl[i].addr, tbl[i].wr, tbl[i].wdata);
      chk($sformatf("tbl%0d_rd", i), readdata, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_irq", i), {31'h0, irq}, {31'h0, tbl[i].exp_irq});
    end

    // Pin change latency: DATA shows the new value exactly 7 edges later
    address = 2'd0;
    in_port = 4'h5;
    for (int k = 1; k <= 7; k++) begin
      cycle();
      chk($sformatf("latency_e%0d", k), readdata, (k >= 7) ? 32'h5 : 32'h0);
    end
    cycle();
    bus(2'd2, 1'b0, 32'h0);
    chk("edgecap_after_5", readdata, 32'h5);

    // 3-cycle glitches (bit0 low, bit1 high) are rejected
    in_port = 4'h6;
    repeat (3) cycle();
    in_port = 4'h5;
    address = 2'd0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk($sformatf("glitch_data_%0d", k), readdata, 32'h5);
    end
    bus(2'd2, 1'b0, 32'h0);
    chk("glitch_edgecap", readdata, 32'h5);

    // Mask enables irq; W1C clears one flag; clearing the mask keeps flags
    bus(2'd1, 1'b1, 32'h1);
    chk("mask1_irq", {31'h0, irq}, 32'h1);
    bus(2'd2, 1'b1, 32'h1);
    chk("w1c_irq", {31'h0, irq}, 32'h0);
    bus(2'd2, 1'b0, 32'h0);
    chk("w1c_edgecap", readdata, 32'h4);
    bus(2'd1, 1'b1, 32'h4);
    chk("mask4_irq", {31'h0, irq}, 32'h1);
    bus(2'd1, 1'b1, 32'h0);
    chk("unmask_irq", {31'h0, irq}, 32'h0);
    bus(2'd2, 1'b0, 32'h0);
    chk("unmask_keeps_cap", readdata, 32'h4);

    // W1C on bit1 in the very cycle its edge is detected: set wins
    bus(2'd1, 1'b1, 32'h2);
    chk("mask2_irq", {31'h0, irq}, 32'h0);
    in_port = 4'h7;
    address = 2'd0;
    repeat (6) cycle();
    bus(2'd2, 1'b1, 32'h2);
    chk("setwins_irq", {31'h0, irq}, 32'h1);
    bus(2'd2, 1'b0, 32'h0);
    chk("setwins_edgecap", readdata, 32'h6);

    // Reset pulse mid-debounce with all pins high
    in_port = 4'hF;
    repeat (3) cycle();
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_readdata", readdata, 32'h0);
    chk("midrst_irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    address = 2'd1;
    cycle();
    chk("postrst_mask", readdata, 32'h0);
    address = 2'd2;
    cycle();
    chk("postrst_edgecap", readdata, 32'h0);
    address = 2'd0;
    for (int k = 3; k <= 7; k++) begin
      cycle();
      chk($sformatf("postrst_data_e%0d", k), readdata, (k >= 7) ? 32'hF : 32'h0);
    end
    bus(2'd2, 1'b0, 32'h0);
    chk("postrst_edgecap_f", readdata, 32'hF);
    chk("postrst_irq", {31'h0, irq}, 32'h0);

    // Random pins (mix of glitches and accepted changes) and random bus traffic
    for (int i = 0; i < 4; i++) left[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if (left[b] == 0) begin
          in_port[b] = 1'($urandom_range(0, 1));
          left[b] = $urandom_range(1, 9);
        end else begin
          left[b]--;
        end
      end
      address = 2'($urandom_range(0, 3));
      chipselect = ($urandom_range(0, 3) == 0);
      write_n = 1'($urandom_range(0, 1));
      writedata = $urandom;
      cycle();
    end
    chipselect = 1'b0;
    write_n = 1'b1;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
